light_grid_row_engine: RTL



---
 rtl/light_grid_row_engine.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/light_grid_row_engine.sv
// light_grid_row_engine
// Row-at-a-time light-grid evaluator. It makes one pass per grid row: the row
// RAM is cleared, every replayed instruction that covers the row is applied
// cell by cell, and the row is then summed into the brightness accumulator.
// After the last row the total is presented and held until reset.
//
// Ports:
//   clk, reset    single clock, synchronous active-high reset
//   instr_valid   instruction present on instr_data
//   instr_ready   engine accepts the instruction this cycle
//   instr_last    final instruction of the current pass (only on transfer)
//   instr_data    {op[1:0], x1, y1, x2, y2}; op 00 off, 01 on, 10 toggle, 11 no-op
//   result_valid  total brightness is final
//   result        total brightness
//
// Build option: define CELL_SATURATE_EN to make on/toggle saturate the cell
// at its maximum instead of wrapping.
module light_grid_row_engine #(
  parameter int unsigned COORD_WIDTH       = 10,
  parameter int unsigned GRID_SIZE         = 1000,
  parameter int unsigned CELL_WIDTH        = 12,
  parameter int unsigned RESULT_WIDTH      = 32,
  parameter int unsigned INSTRUCTION_WIDTH = 2 + 4 * COORD_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic                         instr_last,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_data,
  output logic                         result_valid,
  output logic [RESULT_WIDTH-1:0]      result
);

  localparam int unsigned ADDR_W = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [COORD_WIDTH-1:0] LAST_IDX = COORD_WIDTH'(GRID_SIZE - 1);

  typedef enum logic [2:0] {S_CLEAR, S_WAIT, S_APPLY, S_SUM, S_DONE} state_t;

  state_t                  r_state, w_state_next;
  logic [COORD_WIDTH-1:0]  r_row, r_x, r_x2;
  logic [CNT_W-1:0]        r_cnt;
  logic [1:0]              r_op;
  logic                    r_last;
  logic [RESULT_WIDTH-1:0] r_acc, r_result;
  logic                    r_result_valid, r_instr_ready;
  logic                    r_wb_vld, r_sum_vld;
  logic [ADDR_W-1:0]       r_wb_addr;
  logic [CELL_WIDTH-1:0]   r_rd;
  logic [CELL_WIDTH-1:0]   r_mem [GRID_SIZE];

  logic [1:0]              w_op;
  logic [COORD_WIDTH-1:0]  w_x1, w_y1, w_x2, w_y2, w_x2c;
  logic                    w_xfer, w_hit, w_fwd, w_we;
  logic [ADDR_W-1:0]       w_raddr, w_waddr;
  logic [CELL_WIDTH-1:0]   w_wdata, w_new, w_inc, w_inc_amt;
  logic [RESULT_WIDTH-1:0] w_acc_next;
`ifdef CELL_SATURATE_EN
  logic [CELL_WIDTH:0]     w_sum_ext;
`endif

  assign instr_ready  = r_instr_ready;
  assign result_valid = r_result_valid;
  assign result       = r_result;

  // Instruction field decode and coverage test for the current row
  assign w_op   = instr_data[INSTRUCTION_WIDTH-1 -: 2];
  assign w_x1   = instr_data[4*COORD_WIDTH-1 -: COORD_WIDTH];
  assign w_y1   = instr_data[3*COORD_WIDTH-1 -: COORD_WIDTH];
  assign w_x2   = instr_data[2*COORD_WIDTH-1 -: COORD_WIDTH];
  assign w_y2   = instr_data[COORD_WIDTH-1:0];
  assign w_x2c  = (w_x2 > LAST_IDX) ? LAST_IDX : w_x2;
  assign w_xfer = instr_valid && (r_state == S_WAIT);
  assign w_hit  = (w_y1 <= r_row) && (r_row <= w_y2) && (w_x1 <= w_x2c) && (w_op != 2'b11);

  assign w_acc_next = r_acc + RESULT_WIDTH'(r_rd);

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR: if (r_cnt == CNT_W'(GRID_SIZE - 1)) w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_xfer) begin
          if (w_hit)           w_state_next = S_APPLY;
          else if (instr_last) w_state_next = S_SUM;
        end
      end
      S_APPLY: if (r_x == r_x2) w_state_next = r_last ? S_SUM : S_WAIT;
      S_SUM: begin
        if (r_cnt == CNT_W'(GRID_SIZE))
          w_state_next = (r_row == LAST_IDX) ? S_DONE : S_CLEAR;
      end
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_CLEAR;
    endcase
  end

  // Cell update applied to the value read one cycle earlier
  always_comb begin
    w_inc_amt = '0;
    if (r_op == 2'b01) w_inc_amt = CELL_WIDTH'(1);
    if (r_op == 2'b10) w_inc_amt = CELL_WIDTH'(2);
`ifdef CELL_SATURATE_EN
    w_sum_ext = {1'b0, r_rd} + {1'b0, w_inc_amt};
    w_inc     = w_sum_ext[CELL_WIDTH] ? '1 : w_sum_ext[CELL_WIDTH-1:0];
`else
    w_inc     = r_rd + w_inc_amt;
`endif
    w_new = w_inc;
    if (r_op == 2'b00) w_new = (r_rd == '0) ? '0 : r_rd - CELL_WIDTH'(1);
  end

  // RAM port muxing; a pending write-back to the address being read is forwarded
  always_comb begin
    w_raddr = (r_state == S_APPLY) ? ADDR_W'(r_x) : ADDR_W'(r_cnt);
    w_we    = r_wb_vld;
    w_waddr = r_wb_addr;
    w_wdata = w_new;
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = ADDR_W'(r_cnt);
      w_wdata = '0;
    end
  end
  assign w_fwd = r_wb_vld && (r_wb_addr == w_raddr);

  // Row RAM with one-cycle registered read
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rd <= w_fwd ? w_new : r_mem[w_raddr];
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_CLEAR;
      r_row          <= '0;
      r_cnt          <= '0;
      r_x            <= '0;
      r_x2           <= '0;
      r_op           <= 2'b11;
      r_last         <= 1'b0;
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_instr_ready  <= 1'b0;
      r_wb_vld       <= 1'b0;
      r_wb_addr      <= '0;
      r_sum_vld      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= (w_state_next != r_state) ? '0 : r_cnt + CNT_W'(1);
      r_instr_ready <= (w_state_next == S_WAIT);
      r_wb_vld      <= (r_state == S_APPLY);
      r_wb_addr     <= ADDR_W'(r_x);
      r_sum_vld     <= (r_state == S_SUM) && (r_cnt < CNT_W'(GRID_SIZE));
      if (r_sum_vld) r_acc <= w_acc_next;
      if (w_xfer) begin
        r_op   <= w_op;
        r_x    <= w_x1;
        r_x2   <= w_x2c;
        r_last <= instr_last;
      end else if ((r_state == S_APPLY) && (r_x != r_x2)) begin
        r_x <= r_x + COORD_WIDTH'(1);
      end
      if ((r_state == S_SUM) && (w_state_next == S_CLEAR)) r_row <= r_row + COORD_WIDTH'(1);
      if ((r_state == S_SUM) && (w_state_next == S_DONE)) begin
        r_result       <= w_acc_next;
        r_result_valid <= 1'b1;
      end
    end
  end

endmodule
